// File: rtl/window_gen_3x3.sv
// window_gen_3x3: streaming 3x3 sliding-window generator for the 3x3 MAC stage.
// Takes one raster-order pixel per cycle, keeps the two previous rows in line
// buffers and presents one valid-only 3x3 window per cycle through a one-entry
// output register with valid/ready flow control.
module window_gen_3x3 #(
    parameter int DATA_WIDTH = 16,
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_pixel,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] px0,
    output logic signed [DATA_WIDTH-1:0] px1,
    output logic signed [DATA_WIDTH-1:0] px2,
    output logic signed [DATA_WIDTH-1:0] px3,
    output logic signed [DATA_WIDTH-1:0] px4,
    output logic signed [DATA_WIDTH-1:0] px5,
    output logic signed [DATA_WIDTH-1:0] px6,
    output logic signed [DATA_WIDTH-1:0] px7,
    output logic signed [DATA_WIDTH-1:0] px8,
    output logic                         out_last
);

    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic          accept;
    logic          emit;

    // linebuf1 holds row r-2, linebuf0 holds row r-1 (indexed by column)
    logic signed [DATA_WIDTH-1:0] linebuf0 [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] linebuf1 [IMG_WIDTH];
    logic signed [DATA_WIDTH-1:0] lb0_rd;
    logic signed [DATA_WIDTH-1:0] lb1_rd;

    // Only the two most recent window columns are stored; the third (newest)
    // column comes straight from the line buffers and in_pixel, so the window
    // presented at the output is {stored cols, new col}.
    logic signed [DATA_WIDTH-1:0] top1, top2;
    logic signed [DATA_WIDTH-1:0] mid1, mid2;
    logic signed [DATA_WIDTH-1:0] bot1, bot2;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign emit     = (row >= RW'(2)) && (col >= CW'(2));
    assign lb0_rd   = linebuf0[col];
    assign lb1_rd   = linebuf1[col];

    // Raster position counters: column wraps into row, row wraps into next frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffers and window columns shift on every accepted pixel (no reset needed)
    always_ff @(posedge clk) begin
        if (accept) begin
            linebuf1[col] <= lb0_rd;
            linebuf0[col] <= in_pixel;
            top1 <= top2;
            top2 <= lb1_rd;
            mid1 <= mid2;
            mid2 <= lb0_rd;
            bot1 <= bot2;
            bot2 <= in_pixel;
        end
    end

    // One-entry output register: load on a completing pixel, clear on transfer, hold on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            px0 <= '0;
            px1 <= '0;
            px2 <= '0;
            px3 <= '0;
            px4 <= '0;
            px5 <= '0;
            px6 <= '0;
            px7 <= '0;
            px8 <= '0;
        end else if (accept && emit) begin
            out_valid <= 1'b1;
            out_last  <= (row == ROW_LAST) && (col == COL_LAST);
            px0 <= top1;
            px1 <= top2;
            px2 <= lb1_rd;
            px3 <= mid1;
            px4 <= mid2;
            px5 <= lb0_rd;
            px6 <= bot1;
            px7 <= bot2;
            px8 <= in_pixel;
        end else if (accept || out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_window_gen_3x3.sv
// tb_window_gen_3x3: directed bench for window_gen_3x3 on a 5x5 image.
module tb_window_gen_3x3;

    localparam int DW   = 16;
    localparam int W    = 5;
    localparam int H    = 5;
    localparam int NWIN = (W - 2) * (H - 2);

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic signed [DW-1:0] in_pixel;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [DW-1:0] px0, px1, px2, px3, px4, px5, px6, px7, px8;
    logic                 out_last;
    logic [9*DW-1:0]      cur_win;

    int checks = 0;
    int errors = 0;

    int              pix_q[$];
    logic [9*DW-1:0] win_q[$];
    logic            last_q[$];
    logic            stall_rdy_q[$];
    logic [9*DW-1:0] stall_win_q[$];
    int              acc_cyc[$];
    int              first_valid_cyc;
    bit              timed_out;
    bit              gap_mode;
    int              rdy_mode;
    bit              drain;

    window_gen_3x3 #(
        .DATA_WIDTH(DW),
        .IMG_WIDTH (W),
        .IMG_HEIGHT(H)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_pixel (in_pixel),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .px0      (px0),
        .px1      (px1),
        .px2      (px2),
        .px3      (px3),
        .px4      (px4),
        .px5      (px5),
        .px6      (px6),
        .px7      (px7),
        .px8      (px8),
        .out_last (out_last)
    );

    assign cur_win = {px0, px1, px2, px3, px4, px5, px6, px7, px8};

    always #5 clk = ~clk;

    // Expected window k of a frame whose pixel (r,c) = base + sgn*(r*W+c)
    function automatic logic [9*DW-1:0] exp_win(input int base, input int sgn, input int k);
        logic [9*DW-1:0] w;
        logic [DW-1:0]   p;
        int wr, wc, v;
        wr = k / (W - 2);
        wc = k % (W - 2);
        w  = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                v = base + sgn * ((wr + i) * W + wc + j);
                p = v[DW-1:0];
                w[(8 - (i * 3 + j)) * DW +: DW] = p;
            end
        end
        return w;
    endfunction

    function automatic void load_frame(input int base, input int sgn);
        for (int i = 0; i < W * H; i++) pix_q.push_back(base + sgn * i);
    endfunction

    // Drive pix_q, collect every output transfer; sampling is 1ns after the falling edge
    task automatic stream();
        int idx = 0;
        int cyc = 0;
        int stall_left = 3;
        int last_acc = -1;
        win_q.delete();
        last_q.delete();
        stall_rdy_q.delete();
        stall_win_q.delete();
        acc_cyc.delete();
        first_valid_cyc = -1;
        timed_out = 1'b0;
        while (1) begin
            @(negedge clk);
            if (rdy_mode == 0) begin
                out_ready = 1'b1;
            end else if (rdy_mode == 1) begin
                out_ready = 1'($urandom_range(0, 1));
            end else if (out_valid && win_q.size() == 4 && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            if (idx < pix_q.size()) begin
                in_valid = gap_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                in_pixel = DW'(pix_q[idx]);
            end else begin
                in_valid = 1'b0;
                in_pixel = '0;
            end
            #1;
            if (drain && idx >= pix_q.size() && cyc > last_acc && !out_valid) break;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (rdy_mode == 2 && out_valid && !out_ready) begin
                stall_rdy_q.push_back(in_ready);
                stall_win_q.push_back(cur_win);
            end
            if (out_valid && out_ready) begin
                win_q.push_back(cur_win);
                last_q.push_back(out_last);
            end
            if (in_valid && in_ready) begin
                acc_cyc.push_back(cyc);
                last_acc = cyc;
                idx++;
            end
            cyc++;
            if (!drain && idx >= pix_q.size()) break;
            if (cyc >= 2000) begin
                timed_out = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_pixel = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got %b exp 0", out_last); end
        checks++;
        if (cur_win !== '0) begin errors++; $display("FAIL reset_px got %h exp 0", cur_win); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    endtask

    task automatic test_basic();
        pix_q.delete();
        load_frame(0, 1);
        gap_mode = 1'b0; rdy_mode = 0; drain = 1'b1;
        stream();
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL basic_timeout got 1 exp 0"); end
        checks++;
        if (win_q.size() != NWIN) begin errors++; $display("FAIL basic_count got %0d exp %0d", win_q.size(), NWIN); end
        for (int k = 0; k < win_q.size() && k < NWIN; k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, 1, k)) begin
                errors++; $display("FAIL basic_win%0d got %h exp %h", k, win_q[k], exp_win(0, 1, k));
            end
            checks++;
            if (last_q[k] !== (k == NWIN - 1)) begin
                errors++; $display("FAIL basic_last%0d got %b exp %b", k, last_q[k], k == NWIN - 1);
            end
        end
        checks++;
        if (acc_cyc.size() < 13 || first_valid_cyc != acc_cyc[12] + 1) begin
            errors++; $display("FAIL basic_latency got %0d exp pixel12 accept + 1", first_valid_cyc);
        end
    endtask

    task automatic test_stall();
        pix_q.delete();
        load_frame(0, 1);
        gap_mode = 1'b0; rdy_mode = 2; drain = 1'b1;
        stream();
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL stall_timeout got 1 exp 0"); end
        checks++;
        if (win_q.size() != NWIN) begin errors++; $display("FAIL stall_count got %0d exp %0d", win_q.size(), NWIN); end
        for (int k = 0; k < win_q.size() && k < NWIN; k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, 1, k)) begin
                errors++; $display("FAIL stall_win%0d got %h exp %h", k, win_q[k], exp_win(0, 1, k));
            end
        end
        checks++;
        if (stall_rdy_q.size() != 3) begin errors++; $display("FAIL stall_cycles got %0d exp 3", stall_rdy_q.size()); end
        for (int s = 0; s < stall_rdy_q.size(); s++) begin
            checks++;
            if (stall_rdy_q[s] !== 1'b0) begin errors++; $display("FAIL stall_in_ready%0d got %b exp 0", s, stall_rdy_q[s]); end
            checks++;
            if (stall_win_q[s] !== exp_win(0, 1, 4)) begin
                errors++; $display("FAIL stall_hold%0d got %h exp %h", s, stall_win_q[s], exp_win(0, 1, 4));
            end
        end
    endtask

    task automatic test_back_to_back();
        pix_q.delete();
        load_frame(0, 1);
        load_frame(100, 1);
        gap_mode = 1'b0; rdy_mode = 0; drain = 1'b1;
        stream();
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL b2b_timeout got 1 exp 0"); end
        checks++;
        if (win_q.size() != 2 * NWIN) begin errors++; $display("FAIL b2b_count got %0d exp %0d", win_q.size(), 2 * NWIN); end
        for (int k = 0; k < win_q.size() && k < 2 * NWIN; k++) begin
            logic [9*DW-1:0] e;
            e = (k < NWIN) ? exp_win(0, 1, k) : exp_win(100, 1, k - NWIN);
            checks++;
            if (win_q[k] !== e) begin errors++; $display("FAIL b2b_win%0d got %h exp %h", k, win_q[k], e); end
            checks++;
            if (last_q[k] !== (k == NWIN - 1 || k == 2 * NWIN - 1)) begin
                errors++; $display("FAIL b2b_last%0d got %b", k, last_q[k]);
            end
        end
        checks++;
        if (acc_cyc.size() != 2 * W * H || acc_cyc[W * H] != acc_cyc[W * H - 1] + 1) begin
            errors++; $display("FAIL b2b_no_bubble got %0d accepts", acc_cyc.size());
        end
    endtask

    task automatic test_random_gaps();
        pix_q.delete();
        load_frame(0, 1);
        gap_mode = 1'b1; rdy_mode = 1; drain = 1'b1;
        stream();
        checks++;
        if (timed_out !== 1'b0) begin errors++; $display("FAIL gaps_timeout got 1 exp 0"); end
        checks++;
        if (win_q.size() != NWIN) begin errors++; $display("FAIL gaps_count got %0d exp %0d", win_q.size(), NWIN); end
        for (int k = 0; k < win_q.size() && k < NWIN; k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, 1, k)) begin
                errors++; $display("FAIL gaps_win%0d got %h exp %h", k, win_q[k], exp_win(0, 1, k));
            end
            checks++;
            if (last_q[k] !== (k == NWIN - 1)) begin errors++; $display("FAIL gaps_last%0d got %b", k, last_q[k]); end
        end
    endtask

    task automatic test_reset_mid_frame();
        pix_q.delete();
        for (int i = 0; i <= 13; i++) pix_q.push_back(i);
        gap_mode = 1'b0; rdy_mode = 0; drain = 1'b0;
        stream();
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending got %b exp 1", out_valid); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b exp 0", out_valid); end
        checks++;
        if (cur_win !== '0) begin errors++; $display("FAIL midrst_px got %h exp 0", cur_win); end
        @(negedge clk);
        checks++;
        if (out_last !== 1'b0) begin errors++; $display("FAIL midrst_out_last got %b exp 0", out_last); end
        rst_n = 1'b1;
        pix_q.delete();
        load_frame(0, 1);
        drain = 1'b1;
        stream();
        checks++;
        if (win_q.size() != NWIN) begin errors++; $display("FAIL midrst_count got %0d exp %0d", win_q.size(), NWIN); end
        for (int k = 0; k < win_q.size() && k < NWIN; k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, 1, k)) begin
                errors++; $display("FAIL midrst_win%0d got %h exp %h", k, win_q[k], exp_win(0, 1, k));
            end
            checks++;
            if (last_q[k] !== (k == NWIN - 1)) begin errors++; $display("FAIL midrst_last%0d got %b", k, last_q[k]); end
        end
    endtask

    task automatic test_negative();
        logic [9*DW-1:0] first;
        pix_q.delete();
        load_frame(0, -1);
        gap_mode = 1'b0; rdy_mode = 0; drain = 1'b1;
        stream();
        first = {16'sd0, -16'sd1, -16'sd2, -16'sd5, -16'sd6, -16'sd7, -16'sd10, -16'sd11, -16'sd12};
        checks++;
        if (win_q.size() != NWIN) begin errors++; $display("FAIL neg_count got %0d exp %0d", win_q.size(), NWIN); end
        checks++;
        if (win_q.size() < 1 || win_q[0] !== first) begin
            errors++; $display("FAIL neg_first got %h exp %h", (win_q.size() > 0) ? win_q[0] : '0, first);
        end
        for (int k = 0; k < win_q.size() && k < NWIN; k++) begin
            checks++;
            if (win_q[k] !== exp_win(0, -1, k)) begin
                errors++; $display("FAIL neg_win%0d got %h exp %h", k, win_q[k], exp_win(0, -1, k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_random_gaps();
        test_reset_mid_frame();
        test_negative();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
